// File: rtl/video_sync_rdctl.sv
// Read-side controller for a video line FIFO: clears the FIFO at each frame start,
// waits for a fill threshold, then bursts one line of pixels with an idle gap between lines.
module video_sync_rdctl #(
    parameter int ADDR_WIDTH = 7,
    parameter int CLR_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  sync_vclk,
    input  logic                  rst,
    input  logic                  vs_in,
    input  logic                  fifo_rdempty,
    input  logic [ADDR_WIDTH-1:0] fifo_rdusedw,
    input  logic [11:0]           cfg_line_len,
    input  logic [ADDR_WIDTH-1:0] cfg_start_th,
    output logic                  fifo_rdreq,
    output logic                  fifo_aclr,
    output logic                  out_de,
    output logic [11:0]           line_cnt,
    output logic                  underflow,
    output logic                  busy
);

    // state   | meaning
    // CLEAR   | frame start: fifo_aclr held for CLR_CYCLES
    // WAIT_TH | waiting for fill level >= threshold and a non-zero line length
    // READ    | reading one line, stalls while the FIFO is empty
    // GAP     | GAP_CYCLES idle cycles after a completed line
    typedef enum logic [1:0] {CLEAR, WAIT_TH, READ, GAP} state_t;

    localparam int CCW = $clog2(CLR_CYCLES + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    state_t         state;
    logic           vs_q;
    logic           vs_edge;
    logic [CCW-1:0] clr_cnt;
    logic [GCW-1:0] gap_cnt;
    logic [11:0]    pix_cnt;
    logic [11:0]    len_q;

    assign vs_edge    = vs_in & ~vs_q;
    assign fifo_rdreq = (state == READ) & ~fifo_rdempty;
    assign fifo_aclr  = (state == CLEAR);
    assign busy       = (state == READ) | (state == GAP);

    // vs_q resets high so a vs_in already high at reset release is not seen as a frame start
    always_ff @(posedge sync_vclk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_TH;
            vs_q      <= 1'b1;
            clr_cnt   <= '0;
            gap_cnt   <= '0;
            pix_cnt   <= '0;
            len_q     <= '0;
            line_cnt  <= '0;
            underflow <= 1'b0;
            out_de    <= 1'b0;
        end else begin
            vs_q   <= vs_in;
            out_de <= fifo_rdreq;
            if (vs_edge) begin
                state     <= CLEAR;
                clr_cnt   <= '0;
                pix_cnt   <= '0;
                line_cnt  <= '0;
                underflow <= 1'b0;
            end else begin
                case (state)
                    CLEAR: begin
                        if (clr_cnt == CCW'(CLR_CYCLES - 1))
                            state <= WAIT_TH;
                        else
                            clr_cnt <= clr_cnt + 1'b1;
                    end
                    WAIT_TH: begin
                        if (fifo_rdusedw >= cfg_start_th && cfg_line_len != 12'd0) begin
                            state   <= READ;
                            len_q   <= cfg_line_len;
                            pix_cnt <= '0;
                        end
                    end
                    READ: begin
                        if (fifo_rdempty) begin
                            underflow <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + 12'd1;
                            if (pix_cnt == len_q - 12'd1) begin
                                state    <= GAP;
                                gap_cnt  <= '0;
                                line_cnt <= line_cnt + 12'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GCW'(GAP_CYCLES - 1))
                            state <= WAIT_TH;
                        else
                            gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: state <= WAIT_TH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_sync_rdctl.sv
// Bench for video_sync_rdctl: directed scenarios plus random traffic, every cycle
// compared against a line/frame-level reference model built from remaining-count bookkeeping.
module tb_video_sync_rdctl;

    localparam int AW  = 7;
    localparam int CLR = 4;
    localparam int GAP = 2;

    localparam int P_CLR  = 0;
    localparam int P_WAIT = 1;
    localparam int P_RD   = 2;
    localparam int P_GAP  = 3;

    logic          sync_vclk = 1'b0;
    logic          rst;
    logic          vs_in;
    logic          fifo_rdempty;
    logic [AW-1:0] fifo_rdusedw;
    logic [11:0]   cfg_line_len;
    logic [AW-1:0] cfg_start_th;
    logic          fifo_rdreq;
    logic          fifo_aclr;
    logic          out_de;
    logic [11:0]   line_cnt;
    logic          underflow;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;
    int rd_seen = 0;
    int aclr_seen = 0;

    int m_phase;
    int m_left;
    int m_lines;
    int m_uflow;
    int m_vs_prev;
    int m_last_rd;

    video_sync_rdctl #(.ADDR_WIDTH(AW), .CLR_CYCLES(CLR), .GAP_CYCLES(GAP)) dut (
        .sync_vclk    (sync_vclk),
        .rst          (rst),
        .vs_in        (vs_in),
        .fifo_rdempty (fifo_rdempty),
        .fifo_rdusedw (fifo_rdusedw),
        .cfg_line_len (cfg_line_len),
        .cfg_start_th (cfg_start_th),
        .fifo_rdreq   (fifo_rdreq),
        .fifo_aclr    (fifo_aclr),
        .out_de       (out_de),
        .line_cnt     (line_cnt),
        .underflow    (underflow),
        .busy         (busy)
    );

    always #5 sync_vclk = ~sync_vclk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_WAIT;
        m_left    = 0;
        m_lines   = 0;
        m_uflow   = 0;
        m_vs_prev = 1;
        m_last_rd = 0;
    endtask

    task automatic model_step(input int rd);
        if (vs_in && !m_vs_prev) begin
            m_phase = P_CLR;
            m_left  = CLR;
            m_lines = 0;
            m_uflow = 0;
        end else begin
            case (m_phase)
                P_CLR: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (fifo_rdusedw >= cfg_start_th && cfg_line_len != 0) begin
                        m_phase = P_RD;
                        m_left  = cfg_line_len;
                    end
                end
                P_RD: begin
                    if (fifo_rdempty) begin
                        m_uflow = 1;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = P_GAP;
                            m_left  = GAP;
                            m_lines = (m_lines + 1) % 4096;
                        end
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_WAIT;
                end
            endcase
        end
        m_vs_prev = vs_in;
        m_last_rd = rd;
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic tick();
        int e_rd;
        #1;
        e_rd = (m_phase == P_RD && !fifo_rdempty) ? 1 : 0;
        check("rdreq", fifo_rdreq, e_rd);
        check("aclr", fifo_aclr, (m_phase == P_CLR) ? 1 : 0);
        check("busy", busy, (m_phase == P_RD || m_phase == P_GAP) ? 1 : 0);
        check("out_de", out_de, m_last_rd);
        check("line_cnt", line_cnt, m_lines);
        check("underflow", underflow, m_uflow);
        rd_seen   += fifo_rdreq;
        aclr_seen += fifo_aclr;
        @(posedge sync_vclk);
        if (rst) model_reset();
        else     model_step(e_rd);
        @(negedge sync_vclk);
    endtask

    task automatic frame_start();
        vs_in = 1'b0;
        tick();
        vs_in = 1'b1;
        tick();
        repeat (CLR) tick();
    endtask

    initial begin
        rst          = 1'b1;
        vs_in        = 1'b1;
        fifo_rdempty = 1'b0;
        fifo_rdusedw = '0;
        cfg_line_len = 12'd8;
        cfg_start_th = 7'd4;
        model_reset();
        @(negedge sync_vclk);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("no_clear_after_reset", aclr_seen, 0);

        // threshold start with a ramping fill level
        frame_start();
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            fifo_rdusedw = (i <= 10) ? AW'(i) : '0;
            tick();
        end
        check("th_reads", rd_seen, 8);
        check("th_lines", line_cnt, 1);

        // vs edge mid-line clears the frame
        vs_in = 1'b0;
        fifo_rdusedw = 7'd10;
        repeat (4) tick();
        vs_in = 1'b1;
        tick();
        fifo_rdusedw = '0;
        aclr_seen = 0;
        rd_seen = 0;
        repeat (8) tick();
        check("clr_aclr_len", aclr_seen, CLR);
        check("clr_reads", rd_seen, 0);
        check("clr_lines", line_cnt, 0);
        check("clr_uflow", underflow, 0);

        // underflow stall mid-line
        frame_start();
        cfg_line_len = 12'd16;
        fifo_rdusedw = 7'd20;
        rd_seen = 0;
        tick();
        fifo_rdusedw = '0;
        repeat (5) tick();
        fifo_rdempty = 1'b1;
        repeat (3) tick();
        fifo_rdempty = 1'b0;
        repeat (15) tick();
        check("uf_reads", rd_seen, 16);
        check("uf_flag", underflow, 1);
        check("uf_lines", line_cnt, 1);

        // zero line length disables reads
        cfg_line_len = 12'd0;
        fifo_rdusedw = 7'd127;
        rd_seen = 0;
        repeat (12) tick();
        check("dis_reads", rd_seen, 0);
        check("dis_busy", busy, 0);

        // line length latched at line start
        cfg_line_len = 12'd8;
        tick();
        fifo_rdusedw = '0;
        rd_seen = 0;
        repeat (2) tick();
        cfg_line_len = 12'd4;
        repeat (8) tick();
        check("latch_first", rd_seen, 8);
        fifo_rdusedw = 7'd127;
        tick();
        fifo_rdusedw = '0;
        rd_seen = 0;
        repeat (8) tick();
        check("latch_second", rd_seen, 4);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 149) == 0) vs_in = ~vs_in;
            fifo_rdempty = ($urandom_range(0, 9) < 2);
            fifo_rdusedw = AW'($urandom_range(0, 127));
            cfg_start_th = AW'($urandom_range(0, 40));
            if ($urandom_range(0, 19) == 0) cfg_line_len = 12'($urandom_range(0, 12));
            tick();
        end

        // async reset mid-line with vs held high
        fifo_rdempty = 1'b0;
        cfg_start_th = 7'd4;
        cfg_line_len = 12'd8;
        frame_start();
        fifo_rdusedw = 7'd127;
        repeat (14) tick();
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_rdreq", fifo_rdreq, 0);
        check("rst_out_de", out_de, 0);
        check("rst_busy", busy, 0);
        check("rst_lines", line_cnt, 0);
        model_reset();
        @(negedge sync_vclk);
        rst = 1'b0;
        aclr_seen = 0;
        repeat (10) tick();
        check("rst_no_clear", aclr_seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
